multicycle_sequencer: RTL

Multi-cycle control sequencer that steps the RISC datapath through FETCH, DECODE, EXECUTE, MEM and WRITEBACK using a single shared instruction/data memory port. It sits beside the combinational opcode controller. It owns all state-changing strobes: PC write, IR write, register-file write enable, memory request/write. It also counts retired instructions and traps illegal opcodes.

---
 rtl/seq_pkg.sv | 53 +++++
 rtl/seq_op_decode.sv | 44 ++++
 rtl/multicycle_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared types and constants for the multi-cycle control sequencer:
//   - seq_state_e : sequencer FSM states
//   - OP_*        : 6-bit opcode encodings seen in the IR opcode field
//   - op_class_e  : opcode classes that steer the FSM
//   - retires_in_exec() : classes whose instruction completes in EXEC
// ---------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_ERROR
    } seq_state_e;

    // ALU opcodes occupy 000000 up to and including OP_ALU_LAST.
    localparam logic [5:0] OP_ALU_LAST    = 6'b000100;
    localparam logic [5:0] OP_LOAD        = 6'b000101;
    localparam logic [5:0] OP_STORE       = 6'b000110;
    localparam logic [5:0] OP_B           = 6'b000111;
    localparam logic [5:0] OP_BL          = 6'b001000;
    localparam logic [5:0] OP_BCY         = 6'b001001;
    localparam logic [5:0] OP_BNCY        = 6'b001010;
    localparam logic [5:0] OP_BR          = 6'b001011;
    localparam logic [5:0] OP_BCOMP_FIRST = 6'b001100;
    localparam logic [5:0] OP_BCOMP_LAST  = 6'b001110;
    localparam logic [5:0] OP_ILLEGAL     = 6'b001111;

    typedef enum logic [3:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_B,
        CLS_BL,
        CLS_BCOND,
        CLS_BR,
        CLS_BCOMP,
        CLS_ILLEGAL
    } op_class_e;

    // Branches other than BL touch neither memory nor the register file, so
    // they update the PC and retire directly from EXEC.
    function automatic logic retires_in_exec(input op_class_e cls);
        return (cls == CLS_B) || (cls == CLS_BCOND) ||
               (cls == CLS_BR) || (cls == CLS_BCOMP);
    endfunction

endpackage

// File: rtl/seq_op_decode.sv
// ---------------------------------------------------------------------------
// seq_op_decode
// Purely combinational mapping of the 6-bit IR opcode field to its class.
// Any opcode with a non-zero upper pair of bits, or the reserved 001111
// encoding, is classed ILLEGAL.
// Ports:
//   opcode_i   in  6  IR opcode field
//   op_class_o out    decoded opcode class (op_class_e)
// ---------------------------------------------------------------------------
module seq_op_decode
    import seq_pkg::*;
(
    input  logic [5:0] opcode_i,
    output op_class_e  op_class_o
);

    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        op_class_o = CLS_ILLEGAL;
        if (opcode_i[5:4] == 2'b00) begin
            if (opcode_i <= OP_ALU_LAST) begin
                op_class_o = CLS_ALU;
            end else if (opcode_i == OP_LOAD) begin
                op_class_o = CLS_LOAD;
            end else if (opcode_i == OP_STORE) begin
                op_class_o = CLS_STORE;
            end else if (opcode_i == OP_B) begin
                op_class_o = CLS_B;
            end else if (opcode_i == OP_BL) begin
                op_class_o = CLS_BL;
            end else if ((opcode_i == OP_BCY) || (opcode_i == OP_BNCY)) begin
                op_class_o = CLS_BCOND;
            end else if (opcode_i == OP_BR) begin
                op_class_o = CLS_BR;
            end else if ((opcode_i >= OP_BCOMP_FIRST) && (opcode_i <= OP_BCOMP_LAST)) begin
                op_class_o = CLS_BCOMP;
            end else if (opcode_i == OP_ILLEGAL) begin
                op_class_o = CLS_ILLEGAL;
            end
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
// Multi-cycle control FSM stepping the RISC datapath through FETCH, DECODE,
// EXEC, MEM and WB over one shared instruction/data memory port. Owns every
// state-changing strobe, counts retired instructions and traps illegal
// opcodes in a sticky ERROR state that only reset leaves.
//
// Optional feature (compile-time macro SEQ_TIMEOUT_EN): memory-wait timeout.
// When defined, TIMEOUT_CYCLES consecutive cycles of memReq=1 with
// memReady=0 send the sequencer to ERROR. When undefined the sequencer waits
// forever and TIMEOUT_CYCLES has no effect.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   leave IDLE and begin fetching (ignored while busy)
//   stop        in   return to IDLE at the next instruction boundary
//   opcode      in   IR opcode field, valid from DECODE onward
//   memReady    in   memory completes the current request this cycle
//   memReq      out  memory request, held until memReady
//   memWe       out  current request is a store
//   memAddrSel  out  0 = PC address, 1 = ALU result address
//   irWrite     out  IR load pulse (FETCH cycle that sees memReady)
//   pcWrite     out  PC update pulse in the last state of an instruction
//   regWriteEn  out  register-file write pulse
//   busy        out  state is neither IDLE nor ERROR
//   error       out  sticky illegal-opcode / timeout flag
//   retired     out  retired-instruction count, wraps modulo 2^COUNT_W
// ---------------------------------------------------------------------------
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int COUNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [5:0]         opcode,
    input  logic               memReady,
    output logic               memReq,
    output logic               memWe,
    output logic               memAddrSel,
    output logic               irWrite,
    output logic               pcWrite,
    output logic               regWriteEn,
    output logic               busy,
    output logic               error,
    output logic [COUNT_W-1:0] retired
);

    seq_state_e         state_q, state_d;
    logic [COUNT_W-1:0] retired_q, retired_d;
    op_class_e          op_class;
    logic               retire;

    seq_op_decode u_op_decode (
        .opcode_i   (opcode),
        .op_class_o (op_class)
    );

`ifdef SEQ_TIMEOUT_EN
    localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    // Value held during the last tolerated wait cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
`else
    // The limit only matters with the timeout built in; this keeps the
    // parameter referenced without creating any hardware.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Next-state and strobe decode. Everything is Moore from state_q except
    // the memReady-qualified completions (irWrite in FETCH, STORE retiring
    // in MEM), which complete in the same cycle the memory answers.
    always_comb begin
        state_d    = state_q;
        memReq     = 1'b0;
        memWe      = 1'b0;
        memAddrSel = 1'b0;
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        regWriteEn = 1'b0;
        retire     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // start wins over a simultaneous stop here.
                if (start) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                memReq = 1'b1;
                if (memReady) begin
                    irWrite = 1'b1;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                state_d = (op_class == CLS_ILLEGAL) ? ST_ERROR : ST_EXEC;
            end

            ST_EXEC: begin
                if ((op_class == CLS_LOAD) || (op_class == CLS_STORE)) begin
                    state_d = ST_MEM;
                end else if ((op_class == CLS_ALU) || (op_class == CLS_BL)) begin
                    state_d = ST_WB;
                end else if (retires_in_exec(op_class)) begin
                    retire = 1'b1;
                end else begin
                    // Unreachable while the IR is stable; fail safe anyway.
                    state_d = ST_ERROR;
                end
            end

            ST_MEM: begin
                memReq     = 1'b1;
                memAddrSel = 1'b1;
                memWe      = (op_class == CLS_STORE);
                if (memReady) begin
                    if (op_class == CLS_STORE) begin
                        retire = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end

            ST_WB: begin
                regWriteEn = 1'b1;
                retire     = 1'b1;
            end

            ST_ERROR: begin
                state_d = ST_ERROR;
            end

            default: begin
                state_d = ST_ERROR;
            end
        endcase

        // Instruction boundary: the only place stop is honoured.
        if (retire) begin
            pcWrite = 1'b1;
            state_d = stop ? ST_IDLE : ST_FETCH;
        end

`ifdef SEQ_TIMEOUT_EN
        // Counter is zero on every entry to FETCH/MEM because it clears in
        // any cycle that is not an unanswered request.
        wait_d = '0;
        if (memReq && !memReady) begin
            if (wait_q == WAIT_LAST) begin
                state_d = ST_ERROR;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
`endif
    end

    // Natural wrap of the adder gives modulo 2^COUNT_W counting.
    assign retired_d = retire ? retired_q + 1'b1 : retired_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    assign busy    = (state_q != ST_IDLE) && (state_q != ST_ERROR);
    assign error   = (state_q == ST_ERROR);
    assign retired = retired_q;

endmodule
